fifo_burst_reader: RTL and testbench

Drain-side controller for the transfer-test data path: consumes words from the read port of the synchronous FIFO and serialises each DATA_WIDTH-bit word into bytes for the 8-bit host transmit channel. On `start` it moves a programmed number of words, stalling on FIFO empty and on downstream back-pressure. It then pulses `done`. It is the reader counterpart of the FIFO's write-side producer.

---
 rtl/fifo_burst_pkg.sv | 22 ++
 rtl/word_to_byte_serializer.sv | 80 ++++++++
 rtl/fifo_burst_reader.sv | 163 ++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_pkg.sv
// Shared constants for the FIFO burst reader: FSM state codes and word/byte sizing helpers.
package fifo_burst_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_SEND   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Byte-index width, kept at least one bit so single-byte words still elaborate.
  function automatic int unsigned idx_width(input int unsigned n_bytes);
    return (n_bytes > 1) ? $clog2(n_bytes) : 1;
  endfunction

endpackage

// File: rtl/word_to_byte_serializer.sv
// Loads one FIFO word and presents it byte by byte on a registered valid/ready port.
module word_to_byte_serializer
  import fifo_burst_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_word,
  input  logic                  flush,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic                  accept_c,
  output logic                  last_c
);

  localparam int unsigned BYTES = bytes_per_word(DATA_WIDTH);
  localparam int unsigned IDX_W = idx_width(BYTES);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;

  function automatic logic [7:0] head(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST) return w[DATA_WIDTH-1 -: 8];
    else           return w[7:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] drop_head(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST) return w << 8;
    else           return w >> 8;
  endfunction

  assign accept_c = tx_valid_q && tx_ready;
  assign last_c   = accept_c && (idx_q == IDX_W'(BYTES - 1));

  // A flush only takes effect at an accept, so the byte on the wire always completes.
  always_comb begin
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (load) begin
      shreg_d    = load_word;
      idx_d      = '0;
      tx_data_d  = head(load_word);
      tx_valid_d = 1'b1;
    end else if (accept_c) begin
      if (last_c || flush) begin
        tx_valid_d = 1'b0;
      end else begin
        shreg_d   = drop_head(shreg_q);
        idx_d     = idx_q + IDX_W'(1);
        tx_data_d = head(drop_head(shreg_q));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q    <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a programmed number of words from a synchronous FIFO and streams them out as bytes.
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  rdata_valid,
  output logic                  read_req,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [LEN_WIDTH-1:0]  words_sent
);

  logic [2:0]           state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] words_sent_q, words_sent_d;
  logic                 aborted_q, aborted_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 read_req_q, read_req_d;
  logic                 abort_seen_q, abort_seen_d;
  logic                 word_done_q, word_done_d;

  logic ser_load, ser_flush, ser_accept, ser_last;

  word_to_byte_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_ser (
    .clk       (clk),
    .rst_n     (reset_n),
    .load      (ser_load),
    .load_word (read_data),
    .flush     (ser_flush),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .accept_c  (ser_accept),
    .last_c    (ser_last)
  );

  // read_req is decided one cycle ahead from the registered empty view; only this block pops,
  // so a FIFO seen non-empty stays non-empty into the request cycle.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    words_sent_d = words_sent_q;
    aborted_d    = aborted_q;
    busy_d       = busy_q;
    abort_seen_d = abort_seen_q;
    read_req_d   = 1'b0;
    done_d       = 1'b0;
    word_done_d  = 1'b0;
    ser_load     = 1'b0;
    ser_flush    = 1'b0;

    if (word_done_q) words_sent_d = words_sent_q + LEN_WIDTH'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          words_sent_d = '0;
          aborted_d    = 1'b0;
          abort_seen_d = 1'b0;
          busy_d       = 1'b1;
          len_d        = burst_len;
          if (burst_len != '0) begin
            state_d    = ST_REQ;
            read_req_d = !fifo_empty;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_REQ: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_FINISH;
        end else if (read_req_q) begin
          state_d = ST_WAIT;
        end else begin
          read_req_d = !fifo_empty;
        end
      end
      ST_WAIT: begin
        abort_seen_d = abort_seen_q | abort;
        if (rdata_valid) begin
          ser_load = 1'b1;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        abort_seen_d = abort_seen_q | abort;
        ser_flush    = abort_seen_d;
        if (ser_last) begin
          word_done_d = 1'b1;
          if (abort_seen_d) begin
            aborted_d = 1'b1;
            state_d   = ST_FINISH;
          end else if (words_sent_q + LEN_WIDTH'(1) == len_q) begin
            state_d = ST_FINISH;
          end else begin
            state_d    = ST_REQ;
            read_req_d = !fifo_empty;
          end
        end else if (ser_accept && abort_seen_d) begin
          aborted_d = 1'b1;
          state_d   = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      words_sent_q <= '0;
      aborted_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      read_req_q   <= 1'b0;
      abort_seen_q <= 1'b0;
      word_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      words_sent_q <= words_sent_d;
      aborted_q    <= aborted_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      read_req_q   <= read_req_d;
      abort_seen_q <= abort_seen_d;
      word_done_q  <= word_done_d;
    end
  end

  assign read_req   = read_req_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed and randomized bursts against a queue-based FIFO and byte-stream reference.
module tb_fifo_burst_reader;

  localparam int unsigned DW = 16;
  localparam int unsigned LW = 16;
  localparam int          B  = DW / 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, tx_ready = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic [DW-1:0] read_data = '0;
  logic          rdata_valid = 1'b0;
  wire           fifo_empty;
  logic          read_req, tx_valid, busy, done, aborted;
  logic [7:0]    tx_data;
  logic [LW-1:0] words_sent;

  logic          l_start = 1'b0, l_rdata_valid = 1'b0;
  logic [LW-1:0] l_burst_len = '0;
  logic [DW-1:0] l_read_data = 16'h1234;
  logic          l_read_req, l_tx_valid, l_busy, l_done, l_aborted;
  logic [7:0]    l_tx_data;
  logic [LW-1:0] l_words_sent;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .burst_len(burst_len),
    .fifo_empty(fifo_empty), .read_data(read_data), .rdata_valid(rdata_valid),
    .read_req(read_req), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .aborted(aborted), .words_sent(words_sent));

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .start(l_start), .abort(1'b0), .burst_len(l_burst_len),
    .fifo_empty(1'b0), .read_data(l_read_data), .rdata_valid(l_rdata_valid),
    .read_req(l_read_req), .tx_data(l_tx_data), .tx_valid(l_tx_valid), .tx_ready(1'b1),
    .busy(l_busy), .done(l_done), .aborted(l_aborted), .words_sent(l_words_sent));

  // Reference FIFO: pushes come from the stimulus, pops answer read_req one cycle later.
  logic [DW-1:0] mem [0:1023];
  int push_cnt = 0;
  int pop_cnt  = 0;
  assign fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    rdata_valid <= 1'b0;
    if (read_req && (push_cnt != pop_cnt)) begin
      read_data   <= mem[pop_cnt];
      rdata_valid <= 1'b1;
      pop_cnt     <= pop_cnt + 1;
    end
  end

  always @(posedge clk) l_rdata_valid <= l_read_req;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rx_q [$];
  int sched_cyc [$];
  logic [DW-1:0] sched_word [$];
  int run_ps, rr_cnt, viol, stall_bad, n_done, first_rr, first_tv;
  logic busy_c1, busy_at_done, ab_at_done, done_after;
  logic [LW-1:0] ws_at_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[push_cnt] = w;
    push_cnt++;
  endtask

  function automatic logic [7:0] ref_byte(input logic [DW-1:0] w, input int i, input bit msb);
    logic [DW-1:0] t;
    t = msb ? (w >> (8 * (B - 1 - i))) : (w >> (8 * i));
    return t[7:0];
  endfunction

  // mode: 0 ready always, 1 ready toggles, 2 ready random. abort_at: byte count at which abort fires (-1 none).
  task automatic run_burst(input int len, input int mode, input int abort_at, input bit stray_start,
                           input int max_cyc);
    logic prev_stall, abort_fired;
    logic [7:0] prev_data;
    rx_q.delete();
    rr_cnt = 0; viol = 0; stall_bad = 0; n_done = -1; first_rr = -1; first_tv = -1;
    busy_c1 = 1'b0; busy_at_done = 1'bx; ab_at_done = 1'bx; ws_at_done = 'x; done_after = 1'bx;
    prev_stall = 1'b0; prev_data = '0; abort_fired = 1'b0;
    @(negedge clk);
    run_ps = pop_cnt;
    start = 1'b1; burst_len = LW'(len);
    for (int n = 1; n <= max_cyc && n_done < 0; n++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      if (read_req) begin
        rr_cnt++;
        if (first_rr < 0) first_rr = n;
        if (fifo_empty) viol++;
      end
      while (sched_cyc.size() > 0 && sched_cyc[0] <= n) begin
        void'(sched_cyc.pop_front());
        push(sched_word.pop_front());
      end
      if (stray_start && n == 5) begin start = 1'b1; burst_len = LW'(9); end
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (n % 2 == 1);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (abort_at >= 0 && !abort_fired && tx_valid && rx_q.size() == abort_at) begin
        abort = 1'b1; abort_fired = 1'b1;
      end
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_bad++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (tx_valid && first_tv < 0) first_tv = n;
      if (n == 1) busy_c1 = busy;
      if (done) begin
        n_done = n; busy_at_done = busy; ab_at_done = aborted; ws_at_done = words_sent;
      end
    end
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic verify(input string tag, input int n_reads, input int n_bytes, input int exp_ws,
                        input logic exp_ab);
    chk($sformatf("%s_done_seen", tag), 32'(n_done > 0), 1);
    chk($sformatf("%s_done_pulse", tag), done_after, 0);
    chk($sformatf("%s_nbytes", tag), rx_q.size(), n_bytes);
    for (int i = 0; i < n_bytes && i < rx_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), rx_q[i], ref_byte(mem[run_ps + i / B], i % B, 1'b1));
    chk($sformatf("%s_reads", tag), rr_cnt, n_reads);
    chk($sformatf("%s_words_sent", tag), ws_at_done, exp_ws);
    chk($sformatf("%s_aborted", tag), ab_at_done, exp_ab);
    chk($sformatf("%s_busy_at_done", tag), busy_at_done, 0);
    chk($sformatf("%s_req_on_empty", tag), viol, 0);
    chk($sformatf("%s_stall_unstable", tag), stall_bad, 0);
  endtask

  initial begin
    int c;
    int len;
    logic [7:0] l_rx [$];
    repeat (2) @(negedge clk);
    chk("reset_outputs", {read_req, tx_valid, tx_data, busy, done, aborted, words_sent}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_in_idle", {busy, done, aborted, read_req}, 0);

    // Zero-length burst: done two cycles after start, no FIFO traffic.
    run_burst(0, 0, -1, 1'b0, 20);
    chk("len0_done_cycle", n_done, 2);
    chk("len0_busy_c1", busy_c1, 1);
    verify("len0", 0, 0, 0, 1'b0);

    // Three preloaded words with the sink always ready.
    push(16'h1234); push(16'hABCD); push(16'h00FF);
    run_burst(3, 0, -1, 1'b0, 100);
    chk("b3_first_read_req_cycle", first_rr, 1);
    chk("b3_first_tx_valid_cycle", first_tv, 3);
    chk("b3_done_cycle", n_done, 3 * (2 + B) + 2);
    chk("b3_busy_c1", busy_c1, 1);
    if (rx_q.size() == 6) begin
      chk("b3_lit_first", rx_q[0], 8'h12);
      chk("b3_lit_third", rx_q[2], 8'hAB);
      chk("b3_lit_last", rx_q[5], 8'hFF);
    end
    verify("b3", 3, 6, 3, 1'b0);

    // Empty FIFO at start, words arrive late.
    chk("b2_fifo_empty_at_start", fifo_empty, 1);
    sched_cyc.push_back(3);  sched_word.push_back(16'($urandom));
    sched_cyc.push_back(23); sched_word.push_back(16'($urandom));
    run_burst(2, 0, -1, 1'b0, 200);
    chk("b2_done_after_late_push", 32'(n_done > 23), 1);
    verify("b2", 2, 4, 2, 1'b0);

    // Toggling back-pressure over four words, stray start mid-burst.
    for (int i = 0; i < 4; i++) push(16'($urandom));
    run_burst(4, 1, -1, 1'b1, 200);
    verify("toggle", 4, 4 * B, 4, 1'b0);

    // Abort while the first byte of word 2 is on the wire.
    for (int i = 0; i < 5; i++) push(16'($urandom));
    run_burst(5, 2, B, 1'b0, 300);
    verify("abort", 2, B + 1, 1, 1'b1);

    // Asynchronous reset mid-SEND, then a normal burst that drains the FIFO.
    for (int i = 0; i < 4; i++) push(16'($urandom));
    @(negedge clk);
    start = 1'b1; burst_len = LW'(4);
    @(negedge clk);
    start = 1'b0; tx_ready = 1'b1;
    for (int n = 0; n < 100 && !(words_sent == LW'(1) && tx_valid); n++) @(negedge clk);
    chk("rst_reached_send", {words_sent == LW'(1), tx_valid}, 2'b11);
    #1 reset_n = 1'b0;
    #1 chk("rst_async_outputs", {read_req, tx_valid, tx_data, busy, done, aborted, words_sent}, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_idle_after_release", {busy, done, tx_valid, read_req}, 0);
    len = push_cnt - pop_cnt;
    run_burst(len, 2, -1, 1'b0, 400);
    verify("post_rst", len, len * B, len, 1'b0);

    // Randomized bursts with scattered FIFO pushes and random back-pressure.
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, 6);
      c = 1;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 1) == 1) push(16'($urandom));
        else begin
          c += $urandom_range(0, 8);
          sched_cyc.push_back(c); sched_word.push_back(16'($urandom));
        end
      end
      run_burst(len, 2, -1, 1'b1, 500);
      verify($sformatf("rand%0d", r), len, len * B, len, 1'b0);
    end

    // LSB-first instance: 0x1234 goes out as 34,12.
    @(negedge clk);
    l_start = 1'b1; l_burst_len = LW'(1);
    @(negedge clk);
    l_start = 1'b0;
    for (int n = 0; n < 30 && !l_done; n++) begin
      if (l_tx_valid) l_rx.push_back(l_tx_data);
      @(negedge clk);
    end
    chk("lsb_done", l_done, 1);
    chk("lsb_nbytes", l_rx.size(), 2);
    if (l_rx.size() == 2) chk("lsb_bytes", {l_rx[0], l_rx[1]}, 16'h3412);
    chk("lsb_status", {l_words_sent, l_aborted, l_busy}, {LW'(1), 2'b00});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
